write_buffer: RTL and testbench

Write-through buffer between the data cache and main memory. It queues the cache's write-through stores in a FIFO and drains them to main memory over a req/ack port. It also services cache read-miss word fetches, ordered strictly after all previously queued writes. This hides main-memory write latency from the core: the cache stalls only when the buffer is full or a read is outstanding.

---
 rtl/write_buffer.sv | 143 ++++++++++++++
 tb/tb_write_buffer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : write_buffer
// Purpose  : Write-through store FIFO draining to main memory, with read-miss
//            fetches ordered behind every previously queued store.
// Revision : 1.0 - initial release
// ============================================================================
module write_buffer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic                     rd_valid,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_ready,
  output logic                     rd_done,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_nxt;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_pend;
  logic              rd_pend_nxt;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              rd_take;
  logic              rd_finish;
  logic              start;

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  // Stores are held off while a read waits so the read cannot be starved.
  assign wr_ready    = !full && !rd_pend;
  assign rd_ready    = !rd_pend;
  assign push        = wr_valid && wr_ready;
  assign rd_take     = rd_valid && rd_ready;
  assign pop         = (state == WRITE) && mem_ack;
  assign rd_finish   = (state == READ) && mem_ack;
  assign start       = (state == IDLE) && (state_nxt != IDLE);
  assign count_nxt   = count + CNT_W'(push) - CNT_W'(pop);
  assign rd_pend_nxt = rd_take || (rd_pend && !rd_finish);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A read is issued only once the FIFO is empty, so all earlier stores land first.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rd_pend && empty) state_nxt = READ;
        else if (!empty)      state_nxt = WRITE;
      end
      WRITE, READ: if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (state)
      WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      READ:    mem_req = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_pend   <= 1'b0;
      rd_addr_q <= '0;
      busy      <= 1'b0;
      rd_done   <= 1'b0;
      rd_data   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_nxt;
      rd_pend <= rd_pend_nxt;
      if (rd_take) rd_addr_q <= rd_addr;
      rd_done <= rd_finish;
      if (rd_finish) rd_data <= mem_rdata;
      busy <= (count_nxt != '0) || rd_pend_nxt || (state_nxt != IDLE);
      // Memory address/data are captured on entry and held until the ack.
      if (start) begin
        if (state_nxt == WRITE) begin
          mem_addr  <= fifo_addr[rd_ptr];
          mem_wdata <= fifo_data[rd_ptr];
        end else begin
          mem_addr  <= rd_addr_q;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_buffer
// Purpose  : Directed and random stimulus for write_buffer against a memory
//            model and an ordering-based reference of expected transactions.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_write_buffer;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int MSIZE  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              rd_valid = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_ready;
  logic              rd_done;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic [CNT_W-1:0]  count;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  write_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_done(rd_done), .rd_data(rd_data), .busy(busy), .count(count),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t               wstim[$];     // stores the cache still has to present
  logic [ADDR_W-1:0] rstim[$];     // reads the cache still has to present
  wr_t               expq[$];      // accepted stores not yet written to memory
  logic [DATA_W-1:0] ram     [MSIZE];  // main memory contents
  logic [DATA_W-1:0] ref_mem [MSIZE];  // memory as seen once all accepted stores land
  bit                m_rd_pend;
  logic [ADDR_W-1:0] m_rd_addr;
  logic [DATA_W-1:0] m_rd_val;
  logic [DATA_W-1:0] exp_rd_data;
  bit                done_next;
  int                wait_mode;    // 0 ack tied high, 1 three waits, 2 random waits, 3 never
  int                waits_left;
  bit                prev_req, prev_ack, prev_we;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_wdata;
  int                idle_cnt, wr_txn, rd_txn;
  int                n_cmp, n_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    wstim.delete(); rstim.delete(); expq.delete();
    m_rd_pend = 0; done_next = 0; exp_rd_data = '0;
    prev_req = 0; prev_ack = 0; idle_cnt = 0; waits_left = 0;
    wr_valid = 0; rd_valid = 0;
  endtask

  task automatic step();
    bit ewr, erd, ack;
    wr_t f;
    @(negedge clk);
    ewr = (expq.size() < DEPTH) && !m_rd_pend;
    erd = !m_rd_pend;
    check("wr_ready", wr_ready, ewr);
    check("rd_ready", rd_ready, erd);
    check("count", count, expq.size());
    check("busy", busy, (expq.size() != 0) || m_rd_pend);
    check("rd_done", rd_done, done_next);
    check("rd_data", rd_data, exp_rd_data);
    done_next = 0;
    if (!mem_req && (expq.size() != 0 || m_rd_pend)) idle_cnt++; else idle_cnt = 0;
    check("mem_req_live", idle_cnt < 2, 1'b1);
    if (prev_ack) check("idle_gap", mem_req, 1'b0);

    // memory responder
    ack = 0;
    if (mem_req) begin
      if (prev_req && !prev_ack) begin
        check("hold_we", mem_we, prev_we);
        check("hold_addr", mem_addr, prev_addr);
        if (prev_we) check("hold_wdata", mem_wdata, prev_wdata);
      end else begin
        case (wait_mode)
          0:       waits_left = 0;
          1:       waits_left = 3;
          2:       waits_left = $urandom_range(0, 3);
          default: waits_left = -1;
        endcase
      end
      if (wait_mode == 0 || waits_left == 0) ack = 1;
      else if (waits_left > 0) waits_left--;
      if (ack) begin
        if (mem_we) begin
          wr_txn++;
          check("wr_expected", expq.size() != 0, 1'b1);
          if (expq.size() != 0) begin
            f = expq.pop_front();
            check("wr_addr", mem_addr, f.a);
            check("wr_data", mem_wdata, f.d);
          end
          ram[mem_addr] = mem_wdata;
        end else begin
          rd_txn++;
          check("rd_after_writes", expq.size() == 0, 1'b1);
          check("rd_expected", m_rd_pend, 1'b1);
          check("rd_addr", mem_addr, m_rd_addr);
          mem_rdata   = ram[mem_addr];
          m_rd_pend   = 0;
          done_next   = 1;
          exp_rd_data = m_rd_val;
        end
      end
    end
    mem_ack    = (wait_mode == 0) ? 1'b1 : ack;
    prev_req   = mem_req;
    prev_ack   = mem_req && mem_ack;
    prev_we    = mem_we;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;

    // cache side: a store is ordered ahead of a read offered in the same cycle
    wr_valid = 0;
    rd_valid = 0;
    if (wstim.size() != 0) begin
      wr_valid = 1; wr_addr = wstim[0].a; wr_data = wstim[0].d;
      if (ewr) begin
        expq.push_back(wstim[0]);
        ref_mem[wstim[0].a] = wstim[0].d;
        void'(wstim.pop_front());
      end
    end
    if (rstim.size() != 0) begin
      rd_valid = 1; rd_addr = rstim[0];
      if (erd) begin
        m_rd_pend = 1;
        m_rd_addr = rstim[0];
        m_rd_val  = ref_mem[rstim[0]];
        void'(rstim.pop_front());
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((wstim.size() != 0 || rstim.size() != 0 || expq.size() != 0 || m_rd_pend || done_next)
           && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_done", n < max_cyc, 1'b1);
    run(2);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_mem_req"}, mem_req, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_rd_done"}, rd_done, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_count"}, count, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_wr_ready"}, wr_ready, 1'b1);
    check({tag, "_rd_ready"}, rd_ready, 1'b1);
  endtask

  initial begin
    int t0;
    n_cmp = 0; n_err = 0; wr_txn = 0; rd_txn = 0; wait_mode = 0;
    for (int i = 0; i < MSIZE; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    clear_model();

    #2 rst_n = 0;
    #1 reset_checks("por");
    repeat (3) @(negedge clk);
    rst_n = 1;

    // reset in the middle of a write with three stores queued
    wait_mode = 3;
    for (int i = 0; i < 3; i++) wstim.push_back('{a: ADDR_W'(12'h200 + i), d: $urandom});
    run(6);
    check("t1_count", count, 3);
    check("t1_mem_req", mem_req, 1'b1);
    check("t1_mem_we", mem_we, 1'b1);
    t0 = wr_txn;
    rst_n = 0;
    #1 reset_checks("t1");
    clear_model();
    mem_ack = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    wait_mode = 0;
    run(4);
    check("t1_no_write", wr_txn, t0);

    // single store, ack tied high
    t0 = wr_txn;
    wstim.push_back('{a: 10'h010, d: 32'hDEADBEEF});
    drain(20);
    check("t2_txn", wr_txn - t0, 1);
    check("t2_ram", ram[10'h010], 32'hDEADBEEF);

    // five stores against a stalled memory: four fit, the fifth waits
    wait_mode = 3;
    t0 = wr_txn;
    for (int i = 0; i < 5; i++) wstim.push_back('{a: ADDR_W'(12'h100 + i), d: $urandom});
    run(8);
    check("t3_count_full", count, DEPTH);
    check("t3_wr_ready", wr_ready, 1'b0);
    wait_mode = 0;
    drain(60);
    check("t3_txn", wr_txn - t0, 5);

    // read after two stores to the same region
    wait_mode = 2;
    wstim.push_back('{a: 10'h020, d: 32'h11111111});
    wstim.push_back('{a: 10'h021, d: 32'h22222222});
    run(2);
    rstim.push_back(10'h020);
    drain(60);
    check("t4_rd_data", rd_data, 32'h11111111);

    // store and read to the same address offered together
    wait_mode = 0;
    wstim.push_back('{a: 10'h030, d: 32'hA5A5A5A5});
    rstim.push_back(10'h030);
    drain(40);
    check("t5_rd_data", rd_data, 32'hA5A5A5A5);

    // three wait states per transaction
    wait_mode = 1;
    t0 = wr_txn;
    for (int i = 0; i < 4; i++) wstim.push_back('{a: ADDR_W'(12'h040 + i), d: $urandom});
    rstim.push_back(10'h042);
    drain(120);
    check("t6_txn", wr_txn - t0, 4);

    // random mix with a small address range to stress read-after-write
    wait_mode = 2;
    for (int c = 0; c < 300; c++) begin
      if (wstim.size() < 2 && $urandom_range(0, 1) == 1)
        wstim.push_back('{a: ADDR_W'($urandom_range(0, 15)), d: $urandom});
      if (rstim.size() == 0 && $urandom_range(0, 5) == 0)
        rstim.push_back(ADDR_W'($urandom_range(0, 15)));
      step();
    end
    drain(200);
    check("rand_reads_seen", rd_txn > 3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
